// File: rtl/fetch_redirect_ctrl_if.sv
// ---------------------------------------------------------------------------
// fetch_redirect_ctrl_if
//
// Purpose: bundles the signals between the fetch redirect controller and the
// pipeline around it.
//
// Signals:
//   inStall       stall request from the downstream pipeline register
//   inInstType    4-bit instruction type held in that register
//   inBrTaken     branch-taken flag held in that register
//   inTarget      32-bit redirect target for a taken branch or JAL
//   inHalt        halt request
//   outPC         registered fetch address
//   outPCPlus4    outPC + 4 (combinational, wraps modulo 2^32)
//   outValid      fetch slot valid (1 exactly in RUN)
//   outFlush      one-cycle pulse on the first FLUSH cycle
//   outState      RUN=0, FLUSH=1, LOAD_WAIT=2, HALT=3
//   outFlushCount saturating count of redirects taken
//
// Modports:
//   master  pipeline side: drives the in* signals, observes the out* signals
//   slave   controller side: observes in*, drives out*
// ---------------------------------------------------------------------------
interface fetch_redirect_ctrl_if;
    logic        inStall;
    logic [3:0]  inInstType;
    logic        inBrTaken;
    logic [31:0] inTarget;
    logic        inHalt;
    logic [31:0] outPC;
    logic [31:0] outPCPlus4;
    logic        outValid;
    logic        outFlush;
    logic [1:0]  outState;
    logic [15:0] outFlushCount;

    modport master (
        output inStall, inInstType, inBrTaken, inTarget, inHalt,
        input  outPC, outPCPlus4, outValid, outFlush, outState, outFlushCount
    );

    modport slave (
        input  inStall, inInstType, inBrTaken, inTarget, inHalt,
        output outPC, outPCPlus4, outValid, outFlush, outState, outFlushCount
    );
endinterface

// File: rtl/fetch_redirect_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_redirect_ctrl
//
// Purpose: generates the instruction fetch address. The PC advances by 4 each
// cycle in RUN. A taken branch or JAL reported by the downstream register
// loads the aligned target and squashes BUBBLE_CYCLES fetch slots (FLUSH).
// Any other stall re-fetches the current address after one idle cycle
// (LOAD_WAIT). A halt request parks the PC until reset.
//
// Ports:
//   clk    clock, all state updates on the rising edge
//   reset  asynchronous, active-low reset
//   bus    fetch_redirect_ctrl_if.slave (see interface header for signals)
//
// Parameters:
//   RESET_VALUE    PC loaded on reset
//   OP1_LW         instruction-type code of a load
//   OP1_BR         instruction-type code of a conditional branch
//   OP1_JAL        instruction-type code of a jump-and-link
//   BUBBLE_CYCLES  fetch slots squashed per redirect, legal 1..3
// ---------------------------------------------------------------------------
module fetch_redirect_ctrl #(
    parameter logic [31:0] RESET_VALUE   = 32'h0000_0000,
    parameter logic [3:0]  OP1_LW        = 4'b1001,
    parameter logic [3:0]  OP1_BR        = 4'b0010,
    parameter logic [3:0]  OP1_JAL       = 4'b1011,
    parameter int unsigned BUBBLE_CYCLES = 2
) (
    input logic                   clk,
    input logic                   reset,
    fetch_redirect_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        FLUSH     = 2'd1,
        LOAD_WAIT = 2'd2,
        HALT      = 2'd3
    } stateT;

    // Bubble counter is 2 bits wide, enough for the legal range 1..3.
    localparam logic [1:0] BUBBLE_LOAD = 2'(BUBBLE_CYCLES);

    stateT       stateReg, stateNext;
    logic [31:0] pcReg, pcNext;
    logic [1:0]  bubbleReg, bubbleNext;
    logic        flushReg, flushNext;
    logic [15:0] countReg, countNext;

    logic        redirectEvent;
    logic        loadEvent;
    logic [31:0] alignedTarget;

    // Classify the instruction waiting in the downstream register. Loads and
    // unrecognised types never redirect; they fall into the load path below.
    always_comb begin
        redirectEvent = 1'b0;
        case (bus.inInstType)
            OP1_JAL: redirectEvent = bus.inStall;
            OP1_BR:  redirectEvent = bus.inStall & bus.inBrTaken;
            OP1_LW:  redirectEvent = 1'b0;
            default: redirectEvent = 1'b0;
        endcase
    end

    assign loadEvent     = bus.inStall & ~redirectEvent;
    // Instruction fetch is word aligned: the low two target bits are dropped.
    assign alignedTarget = bus.inTarget & 32'hFFFF_FFFC;

    always_comb begin
        stateNext  = stateReg;
        pcNext     = pcReg;
        bubbleNext = bubbleReg;
        flushNext  = 1'b0;
        countNext  = countReg;

        case (stateReg)
            RUN: begin
                if (bus.inHalt) begin
                    stateNext = HALT;
                end else if (redirectEvent) begin
                    stateNext  = FLUSH;
                    pcNext     = alignedTarget;
                    bubbleNext = BUBBLE_LOAD;
                    flushNext  = 1'b1;
                    countNext  = (countReg == 16'hFFFF) ? countReg : countReg + 16'd1;
                end else if (loadEvent) begin
                    stateNext = LOAD_WAIT;
                end else begin
                    pcNext = pcReg + 32'd4;
                end
            end

            // Inputs describe squashed slots here, so they are not looked at.
            FLUSH: begin
                bubbleNext = bubbleReg - 2'd1;
                if (bubbleReg == 2'd1) begin
                    stateNext = RUN;
                end
            end

            // A redirect arriving while waiting is honoured; anything else
            // returns to RUN with the PC untouched so the address is re-fetched.
            LOAD_WAIT: begin
                if (redirectEvent) begin
                    stateNext  = FLUSH;
                    pcNext     = alignedTarget;
                    bubbleNext = BUBBLE_LOAD;
                    flushNext  = 1'b1;
                    countNext  = (countReg == 16'hFFFF) ? countReg : countReg + 16'd1;
                end else begin
                    stateNext = RUN;
                end
            end

            HALT: begin
                stateNext = HALT;
            end

            default: begin
                stateNext = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateReg  <= RUN;
            pcReg     <= RESET_VALUE;
            bubbleReg <= 2'd0;
            flushReg  <= 1'b0;
            countReg  <= 16'd0;
        end else begin
            stateReg  <= stateNext;
            pcReg     <= pcNext;
            bubbleReg <= bubbleNext;
            flushReg  <= flushNext;
            countReg  <= countNext;
        end
    end

    assign bus.outPC         = pcReg;
    assign bus.outPCPlus4    = pcReg + 32'd4;
    assign bus.outValid      = (stateReg == RUN);
    assign bus.outFlush      = flushReg;
    assign bus.outState      = stateReg;
    assign bus.outFlushCount = countReg;

endmodule

// File: doc/fetch_redirect_ctrl.md
FETCH_REDIRECT_CTRL -- requirements
Module: fetch_redirect_ctrl

Interface
REQ-001 Parameter RESET_VALUE, default 32'h0000_0000: PC loaded on reset.
REQ-002 Parameter OP1_LW, default 4'b1001: instruction-type code of a load.
REQ-003 Parameter OP1_BR, default 4'b0010: instruction-type code of a conditional branch.
REQ-004 Parameter OP1_JAL, default 4'b1011: instruction-type code of a jump-and-link.
REQ-005 Parameter BUBBLE_CYCLES, default 2, legal 1..3: fetch slots squashed per redirect.
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-008 inStall  input  1  stall request from the downstream pipeline register (its isStall).
REQ-009 inInstType  input  4  instruction type held in that downstream register.
REQ-010 inBrTaken  input  1  branch-taken flag held in that downstream register.
REQ-011 inTarget  input  32  redirect target address for a taken branch or JAL.
REQ-012 inHalt  input  1  halt request; sampled only in RUN.
REQ-013 outPC  output  32  fetch address, registered.
REQ-014 outPCPlus4  output  32  outPC + 4, combinational, modulo 2^32.
REQ-015 outValid  output  1  fetch slot valid; 1 exactly when state is RUN.
REQ-016 outFlush  output  1  registered one-cycle pulse marking the first cycle of FLUSH.
REQ-017 outState  output  2  state encoding: RUN=0, FLUSH=1, LOAD_WAIT=2, HALT=3.
REQ-018 outFlushCount  output  16  count of redirects taken, saturating at 16'hFFFF.

Function
REQ-019 Redirect event: inStall=1 and (inInstType==OP1_JAL or (inInstType==OP1_BR and inBrTaken=1)).
REQ-020 Load event: inStall=1 and not a redirect event; this covers OP1_LW and any other type.
REQ-021 Event priority, evaluated on every edge: inHalt (RUN only) > redirect > load > normal advance.
REQ-022 RUN, no event: outPC <= outPC + 4 each edge, wrapping 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-023 RUN, redirect event: next outPC = {inTarget[31:2],2'b00}; next state FLUSH; counter loads BUBBLE_CYCLES; outFlush is 1 for the next cycle only; outFlushCount increments.
REQ-024 FLUSH: outPC held; outValid=0; the counter decrements each edge; on the edge where the counter equals 1, next state is RUN; FLUSH lasts exactly BUBBLE_CYCLES cycles.
REQ-025 FLUSH ignores inStall, inInstType, inBrTaken and inHalt, because the in-flight slots are squashed.
REQ-026 RUN, load event: outPC held; next state LOAD_WAIT for exactly 1 cycle; outValid=0 in that cycle.
REQ-027 LOAD_WAIT, redirect event: handled as in REQ-023 (target loaded, enter FLUSH).
REQ-028 LOAD_WAIT, any other input: return to RUN with outPC unchanged, so the held address is re-fetched.
REQ-029 RUN, inHalt=1: next state HALT; outPC held.
REQ-030 HALT: outValid=0 and outPC held until reset.
REQ-031 After the first RUN cycle following FLUSH, outPC equals the aligned target with outValid=1, then advances +4.
REQ-032 outFlushCount stays at 16'hFFFF once saturated; a redirect at saturation changes nothing else.
REQ-033 No combinational path exists from any input to outPC, outFlush, outState or outFlushCount.

Reset
REQ-034 While reset=0, immediately and independent of clk: outPC=RESET_VALUE, state=RUN, counter=0, outFlush=0, outFlushCount=0.
REQ-035 While reset=0, outValid=1 and outPCPlus4=RESET_VALUE+4.
REQ-036 Reset asserted mid-FLUSH, mid-LOAD_WAIT or in HALT aborts the state immediately; the pending redirect target is discarded.
REQ-037 First edge after reset release with no event: outPC=RESET_VALUE+4.

Verification
REQ-038 Reset, no events for 4 edges -> outPC 0,4,8,12,16; outValid=1 throughout; outFlushCount=0.
REQ-039 At outPC=8: inStall=1, inInstType=OP1_BR, inBrTaken=1, inTarget=32'h0000_0103 -> outFlush=1 for 1 cycle; outValid=0 for 2 cycles with outPC=32'h100; then outValid=1 with outPC 0x100, 0x104; outFlushCount=1.
REQ-040 inStall=1 with inInstType=OP1_BR and inBrTaken=0 at outPC=8 -> LOAD_WAIT for 1 cycle with outPC=8 held; then RUN re-fetches 8, then 12.
REQ-041 inStall=1, inInstType=OP1_LW at outPC=0x20, next cycle JAL redirect to 0x400 -> LOAD_WAIT then FLUSH for 2 cycles; RUN resumes at 0x400.
REQ-042 inHalt=1 at outPC=0x10 -> HALT, outValid=0, outPC=0x10 for 10 edges despite a redirect; async reset pulse -> outPC=0, state=RUN without a clock edge.
REQ-043 Force 65536 redirects with BUBBLE_CYCLES=1 -> outFlushCount saturates at 16'hFFFF; outPC wrap check from 32'hFFFF_FFFC -> 0.
